// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage reset/enable sequencer with init, debug halt/step FSM and perf counters
module pipeline_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debug_halt,
    input  logic             debug_step,
    input  logic             is_load_exe,
    input  logic             wb_wen_exe,
    input  logic [4:0]       regw_addr_exe,
    input  logic [4:0]       addr_rs_id,
    input  logic [4:0]       addr_rt_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic             branch_taken_id,
    input  logic             inst_ack,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;
    localparam logic [1:0] STEP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       init_q, init_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic [4:0]       rst_v, en_v;
    logic             active, memw, lu, do_stall, do_flush;

    assign active   = (state_q == RUN) || (state_q == STEP);
    assign memw     = mem_req & ~mem_ack;
    assign lu       = is_load_exe & wb_wen_exe & (regw_addr_exe != 5'd0) &
                      ((rs_used_id & (addr_rs_id == regw_addr_exe)) |
                       (rt_used_id & (addr_rt_id == regw_addr_exe)));
    assign do_stall = active & ~memw & lu;
    assign do_flush = active & ~memw & ~lu & branch_taken_id;

    // state, init counter and perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            init_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // next-state: halt waits for any pending data access to finish
    always_comb begin
        state_d = (state_q == INIT) ? ((init_q == 8'(RST_CYCLES - 1)) ? RUN : INIT) :
                  (state_q == RUN)  ? ((debug_halt & ~memw) ? HALT : RUN) :
                  (state_q == HALT) ? (debug_step ? STEP : (debug_halt ? HALT : RUN)) :
                                      (memw ? STEP : HALT);
        init_d  = (state_q == INIT) ? init_q + 8'd1 : init_q;
        stall_d = (do_stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
        flush_d = (do_flush && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
    end

    // stage controls {if, id, exe, mem, wb} by hazard priority
    always_comb begin
        rst_v = (state_q == INIT) ? 5'b11111 :
                (!active || memw) ? 5'b00000 :
                lu                ? 5'b00100 :
                (branch_taken_id || !inst_ack) ? 5'b01000 : 5'b00000;
        en_v  = (!active || memw) ? 5'b00000 :
                lu                ? 5'b00111 :
                branch_taken_id   ? 5'b11111 :
                !inst_ack         ? 5'b00111 : 5'b11111;
    end

    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_v;
    assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_v;
    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
    localparam int RC  = 4;
    localparam int CW  = 12;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 0, rst = 1, debug_halt = 0, debug_step = 0;
    logic is_load_exe = 0, wb_wen_exe = 0, rs_used_id = 0, rt_used_id = 0;
    logic [4:0] regw_addr_exe = 0, addr_rs_id = 0, addr_rt_id = 0;
    logic branch_taken_id = 0, inst_ack = 1, mem_req = 0, mem_ack = 0;
    logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0] state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.RST_CYCLES(RC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .debug_halt(debug_halt), .debug_step(debug_step),
        .is_load_exe(is_load_exe), .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe),
        .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id), .rs_used_id(rs_used_id),
        .rt_used_id(rt_used_id), .branch_taken_id(branch_taken_id), .inst_ack(inst_ack),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic [4:0] rv;
        logic [4:0] ev;
        int         st;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sbq[$];
    int passed = 0, total = 0;
    int mode = 0, icnt = 0, m_stall = 0, m_flush = 0;

    task automatic chk(input string n, input int act, input int req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    endtask

    // model one cycle from the rules, queue the expected outputs, then advance
    task automatic tick();
        exp_t e;
        int p;
        bit act, memw, lu;
        act  = (mode == 1) || (mode == 3);
        memw = mem_req && !mem_ack;
        lu   = is_load_exe && wb_wen_exe && regw_addr_exe != 0 &&
               ((rs_used_id && addr_rs_id == regw_addr_exe) || (rt_used_id && addr_rt_id == regw_addr_exe));
        p = !act ? 0 : memw ? 1 : lu ? 2 : branch_taken_id ? 3 : !inst_ack ? 4 : 5;
        e.rv = (mode == 0) ? 5'b11111 : (p == 2) ? 5'b00100 : (p == 3 || p == 4) ? 5'b01000 : 5'b00000;
        e.ev = (p == 2 || p == 4) ? 5'b00111 : (p == 3 || p == 5) ? 5'b11111 : 5'b00000;
        e.st = mode;
        e.sc = m_stall;
        e.fc = m_flush;
        sbq.push_back(e);
        if (rst) begin
            mode = 0; icnt = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (p == 2 && m_stall < MAX) m_stall++;
            if (p == 3 && m_flush < MAX) m_flush++;
            case (mode)
                0: begin icnt++; if (icnt == RC) mode = 1; end
                1: if (debug_halt && !memw) mode = 2;
                2: mode = debug_step ? 3 : debug_halt ? 2 : 1;
                default: if (!memw) mode = 2;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {debug_step, is_load_exe, wb_wen_exe, rs_used_id, rt_used_id, branch_taken_id, mem_req, mem_ack} = '0;
        inst_ack = 1;
    endtask

    task automatic set_lu(input logic [4:0] a);
        is_load_exe = 1; wb_wen_exe = 1; regw_addr_exe = a; addr_rs_id = 5; rs_used_id = 1;
    endtask

    // monitor: compare each presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rst_vec", {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, e.rv);
                chk("en_vec", {if_en, id_en, exe_en, mem_en, wb_en}, e.ev);
                chk("state", state, e.st);
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        idle();
        repeat (3) tick();
        rst = 0;
        repeat (RC + 2) tick();
        set_lu(5); tick();
        set_lu(0); tick();
        idle(); tick();
        branch_taken_id = 1; tick();
        set_lu(5); tick();
        idle(); tick();
        inst_ack = 0; tick();
        idle();
        mem_req = 1;
        tick();
        debug_halt = 1;
        repeat (2) tick();
        mem_ack = 1; tick();
        idle();
        repeat (2) tick();
        debug_step = 1; tick();
        debug_step = 0;
        repeat (3) tick();
        debug_step = 1; mem_req = 1; tick();
        debug_step = 0;
        repeat (2) tick();
        mem_ack = 1; tick();
        idle(); tick();
        debug_halt = 0;
        repeat (2) tick();
        set_lu(5);
        repeat (MAX + 3) tick();
        rst = 1; tick();
        rst = 0; idle();
        repeat (RC + 2) tick();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) debug_halt = ~debug_halt;
            debug_step      = ($urandom_range(0, 9) == 0);
            is_load_exe     = 1'($urandom);
            wb_wen_exe      = 1'($urandom);
            regw_addr_exe   = 5'($urandom_range(0, 3));
            addr_rs_id      = 5'($urandom_range(0, 3));
            addr_rt_id      = 5'($urandom_range(0, 3));
            rs_used_id      = 1'($urandom);
            rt_used_id      = 1'($urandom);
            branch_taken_id = ($urandom_range(0, 3) == 0);
            inst_ack        = ($urandom_range(0, 3) != 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ack         = 1'($urandom);
            tick();
        end
        chk("sbq_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
